issue_queue_mw: RTL and testbench
=================================

# issue_queue_mw

Parametrised multi-wide, in-order issue queue between the decoder and the scoreboard/issue_read_operands pair. Accepts up to NrIssuePorts decoded instructions per cycle and presents up to NrIssuePorts instructions per cycle for issue, oldest first. Adds two things the single-wide issue path lacks: decoupling buffering, and a control-flow fence that ends an issue group at a branch. Supports flush of unissued instructions and an issue stall.

## Interface
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration.
- NR_ENTRIES, 8: queue depth; power of two, ≥ 2·NrIssuePorts.
- NrIssuePorts, 2: lanes per side; 1..4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- flush_unissued_instr_i  in  1  drop all queued and incoming instructions.
- stall_i  in  1  suppress all issue-side valids.
- decoded_instr_i  in  NrIssuePorts×scoreboard_entry_t  decoded instructions; lane 0 oldest.
- decoded_instr_valid_i  in  NrIssuePorts  lane valids; must be a prefix (lane i valid ⇒ lanes <i valid).
- is_ctrl_flow_i  in  NrIssuePorts  lane holds a branch/jump.
- decoded_instr_ack_o  out  NrIssuePorts  lane accepted this cycle; prefix.
- issue_instr_o  out  NrIssuePorts×scoreboard_entry_t  head instructions; lane 0 oldest.
- issue_instr_valid_o  out  NrIssuePorts  prefix.
- issue_ack_i  in  NrIssuePorts  consumer takes lane; prefix, subset of valid.
- count_o  out  $clog2(NR_ENTRIES)+1  occupancy.
- full_o  out  1  count_o == NR_ENTRIES.
- stall_issue_o  out  1  count_o ≠ 0 and no issue_ack_i this cycle (performance counter).

## Operation
- Storage: circular buffer of NR_ENTRIES entries {scoreboard_entry_t, ctrl_flow bit}. Pointers are rd_ptr and wr_ptr, $clog2(NR_ENTRIES) bits, and wrap modulo NR_ENTRIES. count is held as a separate register.
- Accept: n_in = min(popcount-prefix of decoded_instr_valid_i, NR_ENTRIES − count). Free space is computed from registered count only. Entries popped in the same cycle are not reused, so there is no combinational path from issue_ack_i to decoded_instr_ack_o. decoded_instr_ack_o[i] = (i < n_in).
- Write: entries for lanes 0..n_in−1 go to wr_ptr+i, and wr_ptr advances by n_in.
- Issue group: lane i is valid when i < count, !stall_i, and no entry at rd_ptr+j (j < i) has ctrl_flow set. A branch is therefore always the last lane of its group.
- Pop: n_out = popcount of issue_ack_i. rd_ptr advances by n_out.
- count_next = count + n_in − n_out. Simultaneous push and pop are legal, including at full (n_in = 0) and empty (n_out = 0).
- Flush: when flush_unissued_instr_i = 1:
  - rd_ptr, wr_ptr and count clear next cycle.
  - decoded_instr_ack_o is forced 0 that cycle.
  - issue_instr_valid_o is forced 0 that cycle.
  - Flush has priority over push, pop and stall.
- Protocol violations are checked by assertions only: a non-prefix valid or ack, or an ack without valid.

## Timing
- Reset: registers clear on the rising edge with rst_ni = 0. While rst_ni = 0, decoded_instr_ack_o, issue_instr_valid_o and stall_issue_o are forced 0. count_o = 0 and full_o = 0 from the first edge.
- Latency: an instruction accepted in cycle t is visible at issue_instr_o in cycle t+1 at the earliest. There is no bypass.
- Throughput: NrIssuePorts per cycle sustained when no branches are present and the queue is not full.
- issue_instr_o is driven directly from storage (mux by rd_ptr). Outputs are stable while not acked.
- Combinational paths: valid→ack and ctrl_flow→issue valid only. There is no ack→ack path across the two sides.

## Structure
- Add a new typedef to ariane_pkg: issue_queue_entry_t {scoreboard_entry_t sbe; logic ctrl_flow;}.
- Pointer-add and prefix-popcount helpers are local functions.
- One natural sub-module, issue_group_fence. It is combinational: it takes the NrIssuePorts head ctrl_flow bits plus count and stall, and produces issue_instr_valid_o. Keeping it separate isolates the fence rule for reuse in the scoreboard.

## Test plan
- Reset with NR_ENTRIES=8, NrIssuePorts=2:
  - Stimulus: rst_ni low 3 cycles, then decoded_instr_valid_i=2'b11.
  - Required: acks are 0 during reset. ack=2'b11 on the first cycle after reset. issue valid=2'b11 one cycle later. count_o=2.
- Fill to full:
  - Stimulus: push 2/cycle with issue_ack_i=0.
  - Required: full_o=1 after 4 cycles. Next push gets ack=2'b00. Then ack 1 lane with 2 lanes offered: ack=2'b00 that cycle, ack=2'b01 the following cycle.
- Pointer wrap:
  - Stimulus: 20 cycles of push 2 / pop 2 with incrementing PCs.
  - Required: issued PC order equals pushed order across the wrap at entry 7→0. count_o stays 2.
- Control-flow fence:
  - Stimulus: queue holds [ALU, BRANCH, ALU].
  - Required: valid=2'b11 with the branch in lane 1. After ack, the group is the single ALU. A queue of [BRANCH, ALU] gives valid=2'b01.
- Flush mid-stream:
  - Stimulus: count_o=5, and flush_unissued_instr_i plus valid inputs asserted together.
  - Required: acks and valids 0 that cycle. count_o=0 next cycle. Subsequent pushes restart normally.
- Stall:
  - Stimulus: stall_i=1 with count_o=3.
  - Required: valid=0, stall_issue_o=1, and pushes are still accepted up to free space.

Source files
------------

// File: rtl/issue_queue_mw_pkg.sv
// Shared types for the multi-wide issue queue: the decoded instruction record
// and the queue storage entry that carries the control-flow fence bit.
package issue_queue_mw_pkg;

    localparam int unsigned DEFAULT_NR_ENTRIES    = 8;
    localparam int unsigned DEFAULT_NR_ISSUE_PORTS = 2;

    typedef enum logic [2:0] {
        FU_NONE   = 3'd0,
        FU_ALU    = 3'd1,
        FU_BRANCH = 3'd2,
        FU_LOAD   = 3'd3,
        FU_STORE  = 3'd4,
        FU_MULT   = 3'd5
    } fu_t;

    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        valid;
    } scoreboard_entry_t;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              ctrl_flow;
    } issue_queue_entry_t;

endpackage

// File: rtl/issue_queue_mw_if.sv
// Decoder-side and issue-side lane bundles of the multi-wide issue queue.
// Handshake: a lane transfers in a cycle where its valid and ack are both 1;
// valid and ack vectors are prefixes (lane i set implies all lanes below set).
interface issue_queue_mw_if #(
    parameter int unsigned NrIssuePorts = 2
) ();
    import issue_queue_mw_pkg::*;

    scoreboard_entry_t [NrIssuePorts-1:0] decoded_instr_i;
    logic              [NrIssuePorts-1:0] decoded_instr_valid_i;
    logic              [NrIssuePorts-1:0] is_ctrl_flow_i;
    logic              [NrIssuePorts-1:0] decoded_instr_ack_o;
    scoreboard_entry_t [NrIssuePorts-1:0] issue_instr_o;
    logic              [NrIssuePorts-1:0] issue_instr_valid_o;
    logic              [NrIssuePorts-1:0] issue_ack_i;

    modport master (
        output decoded_instr_i, decoded_instr_valid_i, is_ctrl_flow_i, issue_ack_i,
        input  decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o
    );

    modport slave (
        input  decoded_instr_i, decoded_instr_valid_i, is_ctrl_flow_i, issue_ack_i,
        output decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o
    );

endinterface

// File: rtl/issue_queue_mw_issue_group_fence.sv
// Issue-group former: lanes are valid up to the occupancy, and a branch
// closes the group so it is always the last valid lane.
module issue_group_fence #(
    parameter int unsigned NrIssuePorts = 2,
    parameter int unsigned CountWidth   = 4
) (
    input  logic [NrIssuePorts-1:0] head_ctrl_flow_i,
    input  logic [CountWidth-1:0]   count_i,
    input  logic                    stall_i,
    output logic [NrIssuePorts-1:0] valid_o
);

    logic blocked;

    always_comb begin
        blocked = 1'b0;
        valid_o = '0;
        for (int i = 0; i < int'(NrIssuePorts); i++) begin
            valid_o[i] = !stall_i && (CountWidth'(i) < count_i) && !blocked;
            blocked    = blocked | head_ctrl_flow_i[i];
        end
    end

endmodule

// File: rtl/issue_queue_mw.sv
// Multi-wide in-order issue queue: circular buffer between decode and issue
// with a branch fence on the issue group, flush of unissued work and stall.
module issue_queue_mw
    import issue_queue_mw_pkg::*;
#(
    parameter int unsigned NR_ENTRIES   = DEFAULT_NR_ENTRIES,
    parameter int unsigned NrIssuePorts = DEFAULT_NR_ISSUE_PORTS
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_unissued_instr_i,
    input  logic                        stall_i,
    issue_queue_mw_if.slave             io,
    output logic [$clog2(NR_ENTRIES):0] count_o,
    output logic                        full_o,
    output logic                        stall_issue_o
);

    localparam int unsigned PW = $clog2(NR_ENTRIES);
    localparam int unsigned CW = PW + 1;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [CW-1:0] n);
        return ptr + n[PW-1:0];
    endfunction

    function automatic logic [CW-1:0] prefix_count(input logic [NrIssuePorts-1:0] v);
        logic          run;
        logic [CW-1:0] n;
        run = 1'b1;
        n   = '0;
        for (int i = 0; i < int'(NrIssuePorts); i++) begin
            run = run & v[i];
            n   = n + CW'(run);
        end
        return n;
    endfunction

    function automatic logic [CW-1:0] pop_count(input logic [NrIssuePorts-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NrIssuePorts); i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic is_prefix(input logic [NrIssuePorts-1:0] v);
        return (v & (v + NrIssuePorts'(1))) == '0;
    endfunction

    issue_queue_entry_t mem_q [NR_ENTRIES];
    issue_queue_entry_t mem_d [NR_ENTRIES];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic [CW-1:0]           free_slots;
    logic [CW-1:0]           n_req;
    logic [CW-1:0]           n_in;
    logic [CW-1:0]           n_out;
    logic [NrIssuePorts-1:0] ack;
    logic [NrIssuePorts-1:0] head_ctrl_flow;
    logic [NrIssuePorts-1:0] fence_valid;
    issue_queue_entry_t      head [NrIssuePorts];
    logic                    active;

    assign active = rst_ni && !flush_unissued_instr_i;

    // Free space comes from the registered count only, so slots popped this
    // cycle are not reused and issue_ack_i never reaches decoded_instr_ack_o.
    always_comb begin
        free_slots = CW'(NR_ENTRIES) - count_q;
        n_req      = prefix_count(io.decoded_instr_valid_i);
        n_in       = (n_req < free_slots) ? n_req : free_slots;
        n_out      = pop_count(io.issue_ack_i);
        if (!active) begin
            n_in  = '0;
            n_out = '0;
        end
        ack = '0;
        for (int i = 0; i < int'(NrIssuePorts); i++) begin
            ack[i] = CW'(i) < n_in;
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < int'(NrIssuePorts); i++) begin
            if (CW'(i) < n_in) begin
                mem_d[ptr_add(wr_ptr_q, CW'(i))] = '{sbe:       io.decoded_instr_i[i],
                                                     ctrl_flow: io.is_ctrl_flow_i[i]};
            end
        end
        wr_ptr_d = ptr_add(wr_ptr_q, n_in);
        rd_ptr_d = ptr_add(rd_ptr_q, n_out);
        count_d  = count_q + n_in - n_out;
        if (flush_unissued_instr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Issue lanes read storage directly; there is no decode-to-issue bypass.
    always_comb begin
        for (int i = 0; i < int'(NrIssuePorts); i++) begin
            head[i]           = mem_q[ptr_add(rd_ptr_q, CW'(i))];
            io.issue_instr_o[i] = head[i].sbe;
            head_ctrl_flow[i] = head[i].ctrl_flow;
        end
    end

    issue_group_fence #(
        .NrIssuePorts (NrIssuePorts),
        .CountWidth   (CW)
    ) i_issue_group_fence (
        .head_ctrl_flow_i (head_ctrl_flow),
        .count_i          (count_q),
        .stall_i          (stall_i),
        .valid_o          (fence_valid)
    );

    assign io.issue_instr_valid_o = active ? fence_valid : '0;
    assign io.decoded_instr_ack_o = ack;
    assign count_o                = count_q;
    assign full_o                 = count_q == CW'(NR_ENTRIES);
    assign stall_issue_o          = rst_ni && (count_q != '0) && (io.issue_ack_i == '0);

    a_valid_prefix : assert property (@(posedge clk_i) disable iff (!rst_ni)
        is_prefix(io.decoded_instr_valid_i));
    a_ack_prefix : assert property (@(posedge clk_i) disable iff (!rst_ni)
        is_prefix(io.issue_ack_i));
    a_ack_needs_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (io.issue_ack_i & ~io.issue_instr_valid_o) == '0);

endmodule

// File: tb/tb_issue_queue_mw.sv
// Scoreboard bench for issue_queue_mw: accepted instructions are queued as
// expected issue order and checked as lanes are acknowledged on issue.
module tb_issue_queue_mw;
    import issue_queue_mw_pkg::*;

    localparam int unsigned NR = 8;
    localparam int unsigned P  = 2;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] count;
    logic       full;
    logic       stall_issue;

    int n_tests = 0;
    int n_fail  = 0;
    logic [34:0] exp_q[$];

    issue_queue_mw_if #(.NrIssuePorts(P)) io ();

    issue_queue_mw #(
        .NR_ENTRIES   (NR),
        .NrIssuePorts (P)
    ) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_ni),
        .flush_unissued_instr_i (flush),
        .stall_i                (stall),
        .io                     (io),
        .count_o                (count),
        .full_o                 (full),
        .stall_issue_o          (stall_issue)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic scoreboard_entry_t mk(input logic [31:0] pc, input fu_t f);
        scoreboard_entry_t e;
        e       = '0;
        e.pc    = pc;
        e.fu    = f;
        e.rd    = pc[6:2];
        e.valid = 1'b1;
        return e;
    endfunction

    task automatic drive(input int n, input logic [31:0] pc, input fu_t f0, input fu_t f1);
        io.decoded_instr_valid_i = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
        io.decoded_instr_i[0]    = mk(pc, f0);
        io.decoded_instr_i[1]    = mk(pc + 32'd4, f1);
        io.is_ctrl_flow_i        = {f1 == FU_BRANCH, f0 == FU_BRANCH};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        io.issue_ack_i = 2'b11;
        repeat (cycles) begin
            @(negedge clk);
            check("drain_valid", io.issue_instr_valid_o, 2'b11);
            tick();
        end
        io.issue_ack_i = 2'b00;
        @(negedge clk);
        check("drain_count", count, 0);
        tick();
    endtask

    // Record every lane the queue accepts as the next expected issue.
    always @(negedge clk) begin
        if (rst_ni) begin
            for (int i = 0; i < int'(P); i++) begin
                if (io.decoded_instr_ack_o[i]) begin
                    exp_q.push_back({io.decoded_instr_i[i].fu, io.decoded_instr_i[i].pc});
                end
            end
        end
    end

    // Monitor: every issued lane must match the oldest expected instruction.
    always @(negedge clk) begin
        logic [34:0] e;
        if (rst_ni) begin
            for (int i = 0; i < int'(P); i++) begin
                if (io.issue_instr_valid_o[i] && io.issue_ack_i[i]) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_underflow: got issue pc %0h, expected no issue",
                                 io.issue_instr_o[i].pc);
                    end else begin
                        e = exp_q.pop_front();
                        if ({io.issue_instr_o[i].fu, io.issue_instr_o[i].pc} !== e) begin
                            n_fail++;
                            $display("FAIL sb_lane%0d: got %0h, expected %0h", i,
                                     {io.issue_instr_o[i].fu, io.issue_instr_o[i].pc}, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        io.issue_ack_i = 2'b00;
        drive(2, 32'h100, FU_ALU, FU_ALU);

        // Reset held while decode offers two lanes.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_ack", io.decoded_instr_ack_o, 2'b00);
            check("rst_valid", io.issue_instr_valid_o, 2'b00);
            check("rst_count", count, 0);
            check("rst_full", full, 0);
            check("rst_stall_issue", stall_issue, 0);
        end
        tick();
        rst_ni = 1'b1;

        // First push after reset, then fill to full.
        @(negedge clk);
        check("post_rst_ack", io.decoded_instr_ack_o, 2'b11);
        check("no_bypass_valid", io.issue_instr_valid_o, 2'b00);
        tick();
        drive(2, 32'h108, FU_ALU, FU_ALU);
        @(negedge clk);
        check("post_rst_count", count, 2);
        check("post_rst_valid", io.issue_instr_valid_o, 2'b11);
        check("fill_ack1", io.decoded_instr_ack_o, 2'b11);
        tick();
        drive(2, 32'h110, FU_ALU, FU_ALU);
        @(negedge clk);
        check("fill_ack2", io.decoded_instr_ack_o, 2'b11);
        tick();
        drive(2, 32'h118, FU_ALU, FU_ALU);
        @(negedge clk);
        check("fill_ack3", io.decoded_instr_ack_o, 2'b11);
        check("not_full_yet", full, 0);
        tick();
        drive(2, 32'h120, FU_ALU, FU_ALU);
        @(negedge clk);
        check("full_flag", full, 1);
        check("full_count", count, 8);
        check("full_ack", io.decoded_instr_ack_o, 2'b00);
        tick();
        io.issue_ack_i = 2'b01;
        @(negedge clk);
        check("full_pop_ack", io.decoded_instr_ack_o, 2'b00);
        check("full_pop_valid", io.issue_instr_valid_o, 2'b11);
        tick();
        io.issue_ack_i = 2'b00;
        @(negedge clk);
        check("refill_ack", io.decoded_instr_ack_o, 2'b01);
        check("refill_count", count, 7);
        tick();
        drive(0, 32'h0, FU_ALU, FU_ALU);
        drain(4);

        // Push two / pop two across several pointer wraps.
        for (int k = 0; k < 20; k++) begin
            drive(2, 32'h200 + 32'(8 * k), FU_ALU, FU_ALU);
            io.issue_ack_i = (k == 0) ? 2'b00 : 2'b11;
            @(negedge clk);
            check("wrap_ack", io.decoded_instr_ack_o, 2'b11);
            if (k > 0) begin
                check("wrap_count", count, 2);
                check("wrap_valid", io.issue_instr_valid_o, 2'b11);
            end
            tick();
        end
        drive(0, 32'h0, FU_ALU, FU_ALU);
        drain(1);

        // Branch closes the issue group.
        drive(2, 32'h300, FU_ALU, FU_BRANCH);
        @(negedge clk);
        check("fence_push1", io.decoded_instr_ack_o, 2'b11);
        tick();
        drive(1, 32'h308, FU_ALU, FU_ALU);
        @(negedge clk);
        check("fence_push2", io.decoded_instr_ack_o, 2'b01);
        tick();
        drive(0, 32'h0, FU_ALU, FU_ALU);
        io.issue_ack_i = 2'b11;
        @(negedge clk);
        check("fence_count", count, 3);
        check("fence_valid_br_last", io.issue_instr_valid_o, 2'b11);
        check("fence_lane1_fu", io.issue_instr_o[1].fu, FU_BRANCH);
        tick();
        io.issue_ack_i = 2'b01;
        @(negedge clk);
        check("fence_tail_valid", io.issue_instr_valid_o, 2'b01);
        check("fence_tail_fu", io.issue_instr_o[0].fu, FU_ALU);
        tick();
        io.issue_ack_i = 2'b00;
        drive(2, 32'h400, FU_BRANCH, FU_ALU);
        @(negedge clk);
        check("fence_push3", io.decoded_instr_ack_o, 2'b11);
        tick();
        drive(0, 32'h0, FU_ALU, FU_ALU);
        io.issue_ack_i = 2'b01;
        @(negedge clk);
        check("fence_br_first_valid", io.issue_instr_valid_o, 2'b01);
        check("fence_br_first_fu", io.issue_instr_o[0].fu, FU_BRANCH);
        tick();
        @(negedge clk);
        check("fence_after_br_valid", io.issue_instr_valid_o, 2'b01);
        check("fence_after_br_fu", io.issue_instr_o[0].fu, FU_ALU);
        tick();
        io.issue_ack_i = 2'b00;
        @(negedge clk);
        check("fence_empty", count, 0);
        tick();

        // Flush with five entries queued and decode offering two more.
        drive(2, 32'h500, FU_ALU, FU_ALU);
        tick();
        drive(2, 32'h508, FU_ALU, FU_ALU);
        tick();
        drive(1, 32'h510, FU_ALU, FU_ALU);
        tick();
        flush = 1'b1;
        drive(2, 32'h600, FU_ALU, FU_ALU);
        exp_q.delete();
        @(negedge clk);
        check("flush_pre_count", count, 5);
        check("flush_ack", io.decoded_instr_ack_o, 2'b00);
        check("flush_valid", io.issue_instr_valid_o, 2'b00);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_count", count, 0);
        check("flush_restart_ack", io.decoded_instr_ack_o, 2'b11);
        tick();
        drive(0, 32'h0, FU_ALU, FU_ALU);
        drain(1);

        // Stall blocks issue but decode still fills free space.
        drive(2, 32'h700, FU_ALU, FU_ALU);
        tick();
        drive(1, 32'h708, FU_ALU, FU_ALU);
        tick();
        stall = 1'b1;
        drive(2, 32'h710, FU_ALU, FU_ALU);
        @(negedge clk);
        check("stall_count", count, 3);
        check("stall_valid", io.issue_instr_valid_o, 2'b00);
        check("stall_issue_flag", stall_issue, 1);
        check("stall_ack1", io.decoded_instr_ack_o, 2'b11);
        tick();
        drive(2, 32'h718, FU_ALU, FU_ALU);
        @(negedge clk);
        check("stall_ack2", io.decoded_instr_ack_o, 2'b11);
        tick();
        drive(2, 32'h720, FU_ALU, FU_ALU);
        @(negedge clk);
        check("stall_count7", count, 7);
        check("stall_ack_partial", io.decoded_instr_ack_o, 2'b01);
        check("stall_valid_still", io.issue_instr_valid_o, 2'b00);
        tick();
        stall = 1'b0;
        drive(0, 32'h0, FU_ALU, FU_ALU);
        drain(4);

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
